fetch_controller: RTL and testbench

- Sequences the 16-bit pipelined RISC front end.
- Owns the program counter and drives the address input of the combinational instruction_memory (6-bit address, 16-bit instruction).
- Loads the IF/ID pipeline register and handles pipeline stall, branch/jump redirect with flush, and halt detection.
- Sits between instruction_memory and the decode stage; hazard and branch logic downstream drive stall and redirect.

---
 rtl/fetch_controller.sv | 119 +++++++++++
 tb/tb_fetch_controller.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Front-end fetch sequencer: owns the PC, feeds the IF/ID register and handles
// stall, redirect-with-flush and halt detection for the 16-bit pipelined core.
module fetch_controller #(
  parameter int          ADDR_W      = 6,
  parameter int          INSTR_W     = 16,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter logic [15:0] NOP_INSTR   = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic               ifid_valid,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0]   ifid_pc_q, ifid_pc_d;
  logic                ifid_valid_q, ifid_valid_d;
  logic [15:0]         fetch_count_q, fetch_count_d;
  logic                is_halt_instr;

  assign is_halt_instr = (imem_instr[INSTR_W-1 -: 4] == HALT_OPCODE);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      ST_IDLE: begin
        ifid_valid_d = 1'b0;
        if (start) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (redirect_valid) begin
          pc_d         = redirect_target;
          ifid_instr_d = INSTR_W'(NOP_INSTR);
          ifid_valid_d = 1'b0;
        end else if (!stall) begin
          ifid_instr_d  = imem_instr;
          ifid_pc_d     = pc_q;
          ifid_valid_d  = 1'b1;
          fetch_count_d = (fetch_count_q == 16'hFFFF) ? fetch_count_q
                                                      : fetch_count_q + 16'd1;
          // A fetched halt parks the PC on itself so a later squash is clean.
          if (is_halt_instr) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end

      ST_HALT: begin
        if (redirect_valid) begin
          pc_d         = redirect_target;
          ifid_instr_d = INSTR_W'(NOP_INSTR);
          ifid_valid_d = 1'b0;
          state_d      = ST_RUN;
        end else if (!stall) begin
          ifid_instr_d = INSTR_W'(NOP_INSTR);
          ifid_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      ifid_instr_q  <= INSTR_W'(NOP_INSTR);
      ifid_pc_q     <= '0;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_valid  = ifid_valid_q;
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: reset/start, stall, redirect, wrap,
// halt/squash and mid-run reset, against hand-computed expected values.
module tb_fetch_controller;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stall;
  logic        redirect_valid;
  logic [5:0]  redirect_target;
  logic [5:0]  imem_addr;
  logic [15:0] imem_instr;
  logic [15:0] ifid_instr;
  logic [5:0]  ifid_pc;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] mem [0:63];
  int          n_vec;
  int          n_miss;

  fetch_controller dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .ifid_instr      (ifid_instr),
    .ifid_pc         (ifid_pc),
    .ifid_valid      (ifid_valid),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  assign imem_instr = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [15:0] instr, input logic [5:0] pc,
                            input logic valid, input logic [15:0] cnt);
    check_val({tag, ".instr"}, 32'(ifid_instr), 32'(instr));
    check_val({tag, ".pc"}, 32'(ifid_pc), 32'(pc));
    check_val({tag, ".valid"}, 32'(ifid_valid), 32'(valid));
    check_val({tag, ".count"}, 32'(fetch_count), 32'(cnt));
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    for (int k = 0; k < 64; k++) mem[k] = 16'h1000 + 16'(k);
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;

    // Reset
    step(); step();
    check_ifid("reset", 16'h0000, 6'd0, 1'b0, 16'd0);
    check_val("reset.halted", 32'(halted), 32'd0);
    check_val("reset.imem_addr", 32'(imem_addr), 32'd0);

    // Start: transition edge, then first fetch edge
    rst = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    check_val("start.valid", 32'(ifid_valid), 32'd0);
    for (int k = 0; k <= 4; k++) begin
      step();
      check_ifid($sformatf("run%0d", k), 16'h1000 + 16'(k), 6'(k), 1'b1, 16'(k + 1));
    end

    // Stall 3 cycles at ifid_pc=4
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_ifid($sformatf("stall%0d", k), 16'h1004, 6'd4, 1'b1, 16'd5);
      check_val($sformatf("stall%0d.addr", k), 32'(imem_addr), 32'd5);
    end
    stall = 1'b0;
    step();
    check_ifid("unstall", 16'h1005, 6'd5, 1'b1, 16'd6);

    // Redirect together with stall
    redirect_valid = 1'b1; redirect_target = 6'd40; stall = 1'b1;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    check_val("redir.valid", 32'(ifid_valid), 32'd0);
    check_val("redir.instr", 32'(ifid_instr), 32'h0000);
    check_val("redir.addr", 32'(imem_addr), 32'd40);
    check_val("redir.count", 32'(fetch_count), 32'd6);
    step();
    check_ifid("redir.fetch", 16'h1028, 6'd40, 1'b1, 16'd7);

    // Wrap-around 62,63,0,1; then mem[3] becomes a halt
    redirect_valid = 1'b1; redirect_target = 6'd62;
    step();
    redirect_valid = 1'b0;
    check_val("wrap.flush", 32'(ifid_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_ifid($sformatf("wrap%0d", k), 16'h1000 + 16'((62 + k) % 64), 6'((62 + k) % 64),
                 1'b1, 16'(8 + k));
    end
    mem[3] = 16'hF000;
    step();
    check_ifid("pre_halt", 16'h1002, 6'd2, 1'b1, 16'd12);

    // Halt
    step();
    check_ifid("halt.fetch", 16'hF000, 6'd3, 1'b1, 16'd13);
    check_val("halt.halted", 32'(halted), 32'd1);
    check_val("halt.addr", 32'(imem_addr), 32'd3);
    step();
    check_ifid("halt.drain", 16'h0000, 6'd3, 1'b0, 16'd13);
    check_val("halt.addr2", 32'(imem_addr), 32'd3);
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("halt.start_ignored", 32'(halted), 32'd1);
    check_val("halt.count_frozen", 32'(fetch_count), 32'd13);

    // Squash the halt with a redirect to 10
    redirect_valid = 1'b1; redirect_target = 6'd10;
    step();
    redirect_valid = 1'b0;
    check_val("squash.halted", 32'(halted), 32'd0);
    check_val("squash.addr", 32'(imem_addr), 32'd10);
    step();
    check_ifid("squash.fetch", 16'h100A, 6'd10, 1'b1, 16'd14);
    for (int k = 11; k <= 20; k++) step();
    check_ifid("at20", 16'h1014, 6'd20, 1'b1, 16'd24);

    // Reset mid-run with stall
    rst = 1'b1; stall = 1'b1;
    step();
    rst = 1'b0; stall = 1'b0;
    check_ifid("midrst", 16'h0000, 6'd0, 1'b0, 16'd0);
    check_val("midrst.halted", 32'(halted), 32'd0);
    check_val("midrst.addr", 32'(imem_addr), 32'd0);
    step(); step(); step();
    check_ifid("idle_hold", 16'h0000, 6'd0, 1'b0, 16'd0);
    check_val("idle_hold.addr", 32'(imem_addr), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_ifid("restart", 16'h1000, 6'd0, 1'b1, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
